// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, wait-counter width and default depth for dmem_responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int CNT_W = 4;
  localparam int DEPTH_WORDS_DEF = 256;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bus between an initiator (master) and dmem_responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port word memory with byte-lane writes and registered read.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       be,
  output logic [31:0]      rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[idx];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory responder (IDLE/WAIT/RESP handshake FSM).
// Define DMEM_BOUNDS_CHECK_EN to flag misaligned/out-of-range accesses with rsp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic we_q, err_q, accept, access, sel_we, err_a;
  logic [31:0] addr_q, wdata_q, sel_addr, sel_wdata, arr_rdata;
  logic [3:0] be_q, sel_be;
  assign accept = bus.req_valid && state_q == IDLE;
  // With zero wait states the access happens on the accept edge, so it must use the live request.
  assign access = rst_n && (state_q == WAIT ? cnt_q == '0 : accept && WAIT_CYCLES == 0);
  assign sel_we = state_q == IDLE ? bus.req_we : we_q;
  assign sel_addr = state_q == IDLE ? bus.req_addr : addr_q;
  assign sel_wdata = state_q == IDLE ? bus.req_wdata : wdata_q;
  assign sel_be = state_q == IDLE ? bus.req_be : be_q;
  assign err_a = CHK && (sel_addr[1:0] != 2'b00 || {2'b00, sel_addr[31:2]} >= 32'(DEPTH_WORDS));
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk  (clk),
    .en   (access),
    .we   (sel_we && !err_a),
    .idx  (sel_addr[IDX_W+1:2]),
    .wdata(sel_wdata),
    .be   (sel_be),
    .rdata(arr_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (accept) begin
      state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
      cnt_d = CNT_W'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
    end else if (state_q == WAIT) begin
      state_d = cnt_q == '0 ? RESP : WAIT;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
    end else if (state_q == RESP && bus.rsp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (accept) begin
        we_q <= bus.req_we;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q <= bus.req_be;
      end
      if (access) err_q <= err_a;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_err = bus.rsp_valid && err_q;
  assign bus.rsp_rdata = bus.rsp_valid && !we_q && !err_q ? arr_rdata : '0;
endmodule
